// File: rtl/fetch_to_decode_arbiter.sv
// Round-robin arbiter that takes one fetch packet per grant into a holding register
// and sends it on the shared fetch-to-decode bus once the bus is free.
// Optional statistics counters are built when F2D_ARB_STATS_EN is defined.
module fetch_to_decode_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = 64,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     bus_is_busy,
  output logic                     bus_send,
  output logic [PKT_W-1:0]         bus_pkt,
  output logic [IDX_W-1:0]         bus_src_id,
  output logic                     arb_idle
`ifdef F2D_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              send_cnt
`endif
);

  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    HOLD = 2'd1,
    COOL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PKT_W-1:0] bus_pkt_q, bus_pkt_d;
  logic [IDX_W-1:0] bus_src_id_q, bus_src_id_d;
  logic             arb_idle_q, arb_idle_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [CW-1:0]    cand;

`ifdef F2D_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] send_cnt_q, send_cnt_d;
`endif

  // Rotating priority scan: the candidate index wraps back to 0 past NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    bus_pkt_d    = bus_pkt_q;
    bus_src_id_d = bus_src_id_q;
    req_ready    = '0;
    bus_send     = 1'b0;
    unique case (state_q)
      ARB: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          bus_pkt_d          = req_pkt[int'(win_idx)*PKT_W +: PKT_W];
          bus_src_id_d       = win_idx;
          state_d            = HOLD;
        end
      end
      HOLD: begin
        if (!bus_is_busy) begin
          bus_send = 1'b1;
          rr_ptr_d = (bus_src_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : bus_src_id_q + IDX_W'(1);
          state_d  = COOL;
        end
      end
      COOL: begin
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
    arb_idle_d = (state_d == ARB);
  end

`ifdef F2D_ARB_STATS_EN
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    send_cnt_d  = send_cnt_q;
    if ((state_q == HOLD) && bus_is_busy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (bus_send) begin
      send_cnt_d = send_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      bus_pkt_q    <= '0;
      bus_src_id_q <= '0;
      arb_idle_q   <= 1'b1;
`ifdef F2D_ARB_STATS_EN
      stall_cnt_q  <= '0;
      send_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      bus_pkt_q    <= bus_pkt_d;
      bus_src_id_q <= bus_src_id_d;
      arb_idle_q   <= arb_idle_d;
`ifdef F2D_ARB_STATS_EN
      stall_cnt_q  <= stall_cnt_d;
      send_cnt_q   <= send_cnt_d;
`endif
    end
  end

  assign bus_pkt    = bus_pkt_q;
  assign bus_src_id = bus_src_id_q;
  assign arb_idle   = arb_idle_q;
`ifdef F2D_ARB_STATS_EN
  assign stall_cnt  = stall_cnt_q;
  assign send_cnt   = send_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_to_decode_arbiter.sv
// Self-checking bench for fetch_to_decode_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level reference model.
module tb_fetch_to_decode_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int IW = 2;

  localparam logic [W-1:0] P0 = 64'h0000_0000_0000_00A5;
  localparam logic [W-1:0] P1 = 64'h1111_0000_0000_0001;
  localparam logic [W-1:0] P2 = 64'h2222_0000_0000_0002;
  localparam logic [W-1:0] P3 = 64'h3333_0000_0000_0003;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_pkt;
  logic [N-1:0]   req_ready;
  logic           bus_is_busy;
  logic           bus_send;
  logic [W-1:0]   bus_pkt;
  logic [IW-1:0]  bus_src_id;
  logic           arb_idle;
`ifdef F2D_ARB_STATS_EN
  logic [15:0]    stall_cnt;
  logic [15:0]    send_cnt;
`endif

  always #5 clk = ~clk;

  fetch_to_decode_arbiter #(.NUM_REQ(N), .PKT_W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_pkt     (req_pkt),
    .req_ready   (req_ready),
    .bus_is_busy (bus_is_busy),
    .bus_send    (bus_send),
    .bus_pkt     (bus_pkt),
    .bus_src_id  (bus_src_id),
    .arb_idle    (arb_idle)
`ifdef F2D_ARB_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .send_cnt    (send_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] v;
    logic         b;
    logic [N-1:0] ready;
    logic         send;
    logic [W-1:0] pkt;
    logic [IW-1:0] src;
    logic         idle;
    logic [15:0]  stall;
    logic [15:0]  sendc;
  } vec_t;

  vec_t vecs[19];

  // Reference model: an optional held packet, a cool-down flag and the next start index.
  bit           m_held;
  bit           m_cool;
  int           m_ptr;
  logic [W-1:0] m_pkt;
  int           m_src;
  int           m_stall;
  int           m_sendc;
  int           m_win_now;
  logic         prev_send;
  int           grant_cnt[N];
  logic [N-1:0] drv_v;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic b);
    req_valid   = v;
    bus_is_busy = b;
  endtask

  task automatic modelReset();
    m_held    = 0;
    m_cool    = 0;
    m_ptr     = 0;
    m_pkt     = '0;
    m_src     = 0;
    m_stall   = 0;
    m_sendc   = 0;
    m_win_now = -1;
    prev_send = 1'b0;
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset_n = 1'b0;
    applyStimulus('0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    drv_v = '0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'(0));
    checkOutput({tag, "_send"},  64'(bus_send),  64'(0));
    checkOutput({tag, "_pkt"},   bus_pkt,        64'(0));
    checkOutput({tag, "_src"},   64'(bus_src_id), 64'(0));
    checkOutput({tag, "_idle"},  64'(arb_idle),  64'(1));
`ifdef F2D_ARB_STATS_EN
    checkOutput({tag, "_stall"}, 64'(stall_cnt), 64'(0));
    checkOutput({tag, "_sendc"}, 64'(send_cnt),  64'(0));
`endif
  endtask

  task automatic modelCheck();
    logic [N-1:0] e_ready;
    logic         e_send;
    int           e_win;
    e_ready = '0;
    e_send  = 1'b0;
    e_win   = -1;
    if (!m_held && !m_cool) begin
      for (int o = 0; o < N; o++) begin
        int i;
        i = (m_ptr + o) % N;
        if (e_win < 0 && req_valid[i]) e_win = i;
      end
    end
    if (e_win >= 0) e_ready[e_win] = 1'b1;
    if (m_held && !bus_is_busy) e_send = 1'b1;
    checkOutput("rnd_ready", 64'(req_ready), 64'(e_ready));
    checkOutput("rnd_send",  64'(bus_send),  64'(e_send));
    checkOutput("rnd_pkt",   bus_pkt,        m_pkt);
    checkOutput("rnd_src",   64'(bus_src_id), 64'(m_src));
    checkOutput("rnd_idle",  64'(arb_idle),  64'(!m_held && !m_cool));
`ifdef F2D_ARB_STATS_EN
    checkOutput("rnd_stall", 64'(stall_cnt), 64'(m_stall));
    checkOutput("rnd_sendc", 64'(send_cnt),  64'(m_sendc & 16'hFFFF));
`endif
    checkOutput("inv_onehot",      64'($onehot0(req_ready)), 64'(1));
    checkOutput("inv_send_busy",   64'(bus_send & bus_is_busy), 64'(0));
    checkOutput("inv_send_consec", 64'(bus_send & prev_send), 64'(0));
    checkOutput("inv_ready_send",  64'((|req_ready) & bus_send), 64'(0));
    prev_send = bus_send;
    m_win_now = e_win;
  endtask

  task automatic modelAdvance();
    if (m_win_now >= 0) begin
      m_held = 1;
      m_pkt  = req_pkt[m_win_now*W +: W];
      m_src  = m_win_now;
      grant_cnt[m_win_now]++;
    end else if (m_held && !bus_is_busy) begin
      m_held  = 0;
      m_cool  = 1;
      m_ptr   = (m_src + 1) % N;
      m_sendc = (m_sendc + 1) % 65536;
    end else if (m_held) begin
      if (m_stall < 65535) m_stall++;
    end else if (m_cool) begin
      m_cool = 0;
    end
  endtask

  task automatic randomPhase(input int cycles, input bit all_valid);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (all_valid) begin
          drv_v[i] = 1'b1;
          if (m_win_now == i) req_pkt[i*W +: W] = {$urandom, $urandom};
        end else if (m_win_now == i) begin
          if ($urandom_range(0, 1) == 1) begin
            drv_v[i] = 1'b1;
            req_pkt[i*W +: W] = {$urandom, $urandom};
          end else begin
            drv_v[i] = 1'b0;
          end
        end else if (drv_v[i]) begin
          if ($urandom_range(0, 31) == 0) drv_v[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          drv_v[i] = 1'b1;
          req_pkt[i*W +: W] = {$urandom, $urandom};
        end
      end
      applyStimulus(drv_v, ($urandom_range(0, 9) < 4));
      #1;
      modelCheck();
      @(posedge clk);
      modelAdvance();
    end
  endtask

  initial begin
    int order[5];
    int gmin, gmax;
    reset_n = 1'b1;
    applyStimulus('0, 1'b0);
    req_pkt = {P3, P2, P1, P0};
    drv_v   = '0;
    modelReset();

    //        v        b     ready    send  pkt  src  idle stall sendc
    vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, '0, 2'd0, 1'b1, 16'd0, 16'd0};
    vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, P0, 2'd0, 1'b0, 16'd0, 16'd0};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, P0, 2'd0, 1'b0, 16'd0, 16'd1};
    vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, P0, 2'd0, 1'b1, 16'd0, 16'd1};
    vecs[4]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, P0, 2'd0, 1'b1, 16'd0, 16'd1};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, P2, 2'd2, 1'b0, 16'd0, 16'd1};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, P2, 2'd2, 1'b0, 16'd1, 16'd1};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, P2, 2'd2, 1'b0, 16'd2, 16'd1};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, P2, 2'd2, 1'b0, 16'd3, 16'd1};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, P2, 2'd2, 1'b0, 16'd4, 16'd1};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, P2, 2'd2, 1'b0, 16'd5, 16'd1};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, P2, 2'd2, 1'b0, 16'd5, 16'd2};
    vecs[12] = '{4'b0101, 1'b0, 4'b0001, 1'b0, P2, 2'd2, 1'b1, 16'd5, 16'd2};
    vecs[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1, P0, 2'd0, 1'b0, 16'd5, 16'd2};
    vecs[14] = '{4'b0100, 1'b0, 4'b0000, 1'b0, P0, 2'd0, 1'b0, 16'd5, 16'd3};
    vecs[15] = '{4'b0100, 1'b0, 4'b0100, 1'b0, P0, 2'd0, 1'b1, 16'd5, 16'd3};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b1, P2, 2'd2, 1'b0, 16'd5, 16'd3};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, P2, 2'd2, 1'b0, 16'd5, 16'd4};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0, P2, 2'd2, 1'b1, 16'd5, 16'd4};

    resetDut();
    checkResetValues("reset");

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      applyStimulus(vecs[k].v, vecs[k].b);
      #1;
      checkOutput($sformatf("vec%0d_ready", k), 64'(req_ready),  64'(vecs[k].ready));
      checkOutput($sformatf("vec%0d_send", k),  64'(bus_send),   64'(vecs[k].send));
      checkOutput($sformatf("vec%0d_pkt", k),   bus_pkt,         vecs[k].pkt);
      checkOutput($sformatf("vec%0d_src", k),   64'(bus_src_id), 64'(vecs[k].src));
      checkOutput($sformatf("vec%0d_idle", k),  64'(arb_idle),   64'(vecs[k].idle));
`ifdef F2D_ARB_STATS_EN
      checkOutput($sformatf("vec%0d_stall", k), 64'(stall_cnt),  64'(vecs[k].stall));
      checkOutput($sformatf("vec%0d_sendc", k), 64'(send_cnt),   64'(vecs[k].sendc));
`endif
    end

    // Reset while a packet is held and the bus is busy.
    @(negedge clk);
    applyStimulus(4'b0010, 1'b1);
    #1 checkOutput("hold_grant", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    applyStimulus(4'b0000, 1'b1);
    #1 checkOutput("hold_src", 64'(bus_src_id), 64'(1));
    checkOutput("hold_nosend", 64'(bus_send), 64'(0));
    #2 reset_n = 1'b0;
    #1 checkResetValues("midrst");
    applyStimulus(4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 checkOutput("post_rst_nosend", 64'(bus_send), 64'(0));
      checkOutput("post_rst_idle", 64'(arb_idle), 64'(1));
    end
    @(negedge clk);
    applyStimulus(4'b1010, 1'b0);
    #1 checkOutput("post_rst_grant", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    applyStimulus(4'b1000, 1'b0);
    #1 checkOutput("post_rst_send", 64'(bus_send), 64'(1));
    checkOutput("post_rst_pkt", bus_pkt, P1);
    checkOutput("post_rst_src", 64'(bus_src_id), 64'(1));

    // All requesters continuously valid: one send every third cycle in index order.
    resetDut();
    order = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      applyStimulus(4'b1111, 1'b0);
      #1;
      checkOutput($sformatf("rr%0d_send", c), 64'(bus_send), 64'((c % 3) == 1));
      checkOutput($sformatf("rr%0d_ready", c), 64'(req_ready),
                  ((c % 3) == 0) ? 64'(1 << order[c / 3]) : 64'(0));
      if ((c % 3) == 1) begin
        checkOutput($sformatf("rr%0d_src", c), 64'(bus_src_id), 64'(order[c / 3]));
      end
    end

    resetDut();
    req_pkt = {P3, P2, P1, P0};
    randomPhase(6000, 1'b0);
    resetDut();
    randomPhase(4000, 1'b1);
    gmin = grant_cnt[0];
    gmax = grant_cnt[0];
    for (int i = 1; i < N; i++) begin
      if (grant_cnt[i] < gmin) gmin = grant_cnt[i];
      if (grant_cnt[i] > gmax) gmax = grant_cnt[i];
    end
    checkOutput("fair_spread", 64'(gmax - gmin <= 1), 64'(1));
    checkOutput("fair_nonzero", 64'(gmin > 0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_to_decode_arbiter.md
Name: fetch_to_decode_arbiter

Overview:
- Shares the single fetch-to-decode bus (is_busy flag plus one packet register) between NUM_REQ fetch requesters, e.g. per-thread fetch units.
- Accepts one packet per grant into a holding register, waits for the bus to be free, then issues a single-cycle send.
- Round-robin fairness; never sends while the bus is busy, so the bus "send while busy" assertion can never fire.
- Sits between the fetch units and the bus, on the sending side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PKT_W, 64, width of a FetchToDecodeBusPacket in bits.
- IDX_W, $clog2(NUM_REQ), requester index width (derived).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  requester i has a packet on req_pkt slice i.
- req_pkt  input  NUM_REQ*PKT_W  packets; slice i = bits [i*PKT_W +: PKT_W].
- req_ready  output  NUM_REQ  one-hot pulse: requester i's packet is taken this cycle.
- bus_is_busy  input  1  bus holds an unconsumed packet.
- bus_send  output  1  one-cycle pulse: write bus_pkt into bus and set busy.
- bus_pkt  output  PKT_W  packet being sent (held register).
- bus_src_id  output  IDX_W  requester index of the held or sent packet.
- arb_idle  output  1  high in ARB state with nothing held.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=ARB, rr_ptr=0.
  - bus_send=0, req_ready=0, bus_pkt=0, bus_src_id=0, arb_idle=1.
- ARB state:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If a winner exists:
    - req_ready[winner]=1 (combinational, same cycle).
    - Register req_pkt slice into bus_pkt and the index into bus_src_id.
    - Next state HOLD.
  - If no request: stay in ARB; req_ready=0.
- HOLD state:
  - If bus_is_busy=0: bus_send=1 this cycle (combinational from state and bus_is_busy).
    - rr_ptr <= bus_src_id+1, wrapping NUM_REQ-1 to 0.
    - Next state COOL.
  - If bus_is_busy=1: stay in HOLD; bus_pkt/bus_src_id stable; bus_send=0.
- COOL state: one cycle, bus_send=0; covers the bus busy flag updating. Next state ARB.
- Latency and throughput:
  - Request to bus_send is 2 cycles minimum (ARB capture, HOLD send).
  - Maximum throughput is one packet per 3 cycles.
- req_ready and bus_send are never asserted in the same cycle.
- req_ready is never asserted outside ARB and is at most one-hot.
- Requesters must hold req_valid and req_pkt stable until req_ready. Dropping req_valid before grant is legal; that request is simply not taken.
- rr_ptr advances only on a completed send, not on capture.
- All requests valid continuously → grant order 0,1,2,3,0,…
- Only requester k valid → k is granted every ARB visit regardless of rr_ptr.
- bus_is_busy rising in the same cycle HOLD is entered: no send; wait until it falls.
- Reset mid-HOLD: held packet discarded, no send, no req_ready pulse after release; the requester's packet was already accepted and is lost by design.
- bus_pkt keeps its last value in ARB/COOL. Consumers use only bus_send to qualify it.

Optional Feature:
- Macro F2D_ARB_STATS_EN.
- When defined:
  - Adds output stall_cnt (16 bits): saturating count of cycles spent in HOLD with bus_is_busy=1.
  - Adds output send_cnt (16 bits): wrapping count of bus_send pulses.
  - Both reset to 0 on reset_n.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then req_valid=0001 with pkt0=0xA5, bus_is_busy=0:
  - Cycle 0: req_ready=0001.
  - Cycle 1: bus_send=1, bus_pkt=0xA5, bus_src_id=0.
  - Cycle 3: arb_idle=1.
- req_valid=1111 held, bus_is_busy=0: bus_send pulses every 3 cycles, bus_src_id sequence 0,1,2,3,0.
- Single request from 2, bus_is_busy=1 for 5 cycles then 0:
  - bus_send stays low 5 cycles, then pulses once with requester 2's packet.
  - Stats build: stall_cnt=5, send_cnt=1.
- rr_ptr=3 after a send, req_valid=0101 → requester 0 granted next, then 2.
- Assert reset_n=0 while in HOLD with bus busy:
  - No bus_send ever issues for the held packet.
  - All outputs at reset values.
  - After release, a fresh request is granted normally, starting at index 0.
- Random req_valid/bus_is_busy for 10k cycles, checked throughout:
  - bus_send never asserted while bus_is_busy=1 or on consecutive cycles.
  - req_ready is at most one-hot.
  - Per-requester grant counts differ by ≤1 under continuous requests.
